run_ctrl: RTL

RUN_CTRL -- requirements
Module: run_ctrl

---
 rtl/run_ctrl_pkg.sv | 18 +
 rtl/run_ctrl_if.sv | 28 ++
 rtl/run_ctrl_sat_counter.sv | 36 +++
 rtl/run_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types for the run controller: FSM state encoding, memory-owner codes
// and the width of the start-up (INIT) counter.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic OWN_HOST = 1'b0;
    localparam logic OWN_CORE = 1'b1;

    // Wide enough for INIT_CYC up to 15.
    localparam int INIT_CW = 4;

endpackage

// File: rtl/run_ctrl_if.sv
// Host/core control bundle for run_ctrl. The timeout flag exists only when
// RUN_CTRL_WDOG_EN is defined.
interface run_ctrl_if #(
    parameter int D  = 12,
    parameter int CW = 16
);
    logic          req;
    logic [D-1:0]  prog_ctr;
    logic          core_rst;
    logic          core_en;
    logic          mem_owner;
    logic          busy;
    logic          done;
    logic [CW-1:0] cycles;
`ifdef RUN_CTRL_WDOG_EN
    logic          timeout;

    modport master (output req, prog_ctr,
                    input  core_rst, core_en, mem_owner, busy, done, cycles, timeout);
    modport slave  (input  req, prog_ctr,
                    output core_rst, core_en, mem_owner, busy, done, cycles, timeout);
`else
    modport master (output req, prog_ctr,
                    input  core_rst, core_en, mem_owner, busy, done, cycles);
    modport slave  (input  req, prog_ctr,
                    output core_rst, core_en, mem_owner, busy, done, cycles);
`endif
endinterface

// File: rtl/run_ctrl_sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones
// instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/run_ctrl.sv
// Start/stop sequencer for a small core: holds it in reset, runs it until its
// PC hits END_PC, then hands memory back to the host. Define RUN_CTRL_WDOG_EN
// to add a RUN-cycle watchdog with a timeout flag.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int          D          = 12,
    parameter int          END_PC     = 128,
    parameter int          INIT_CYC   = 2,
    parameter int          CW         = 16,
    parameter logic [15:0] WDOG_LIMIT = 16'hFFFF
) (
    input  logic       clk,
    input  logic       reset,
    run_ctrl_if.slave  bus
);

    localparam logic [INIT_CW-1:0] INIT_LOAD = INIT_CW'(INIT_CYC - 1);

    state_e             state_q, state_d;
    logic [INIT_CW-1:0] init_cnt_q, init_cnt_d;
    logic [CW-1:0]      cycles;
    logic               end_hit;
    logic               start;
    logic               wdog_hit;

    assign end_hit = (bus.prog_ctr == D'(END_PC));
    assign start   = (state_q == ST_IDLE) && bus.req;

`ifdef RUN_CTRL_WDOG_EN
    logic timeout_q, timeout_d;

    // True on the RUN cycle whose increment brings cycles up to the limit.
    assign wdog_hit = (({1'b0, cycles} + 1'b1) == (CW+1)'(WDOG_LIMIT));
`else
    assign wdog_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // NOTE: every variable gets a default before the case so no latch is
    // inferred on paths that leave it untouched.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    state_d    = ST_INIT;
                    init_cnt_d = INIT_LOAD;
                end
            end
            ST_INIT: begin
                if (init_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    init_cnt_d = init_cnt_q - 1'b1;
                end
            end
            ST_RUN: begin
                if (end_hit || wdog_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!bus.req) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.core_rst  = 1'b1;
        bus.core_en   = 1'b0;
        bus.mem_owner = OWN_HOST;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        case (state_q)
            ST_INIT: begin
                bus.mem_owner = OWN_CORE;
                bus.busy      = 1'b1;
            end
            ST_RUN: begin
                bus.core_rst  = 1'b0;
                bus.core_en   = 1'b1;
                bus.mem_owner = OWN_CORE;
                bus.busy      = 1'b1;
            end
            ST_DONE: begin
                bus.core_rst = 1'b0;
                bus.done     = 1'b1;
            end
            default: ;
        endcase
    end

    sat_counter #(.W(CW)) u_cycles (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (start),
        .en_i    (state_q == ST_RUN),
        .count_o (cycles)
    );

    assign bus.cycles = cycles;

`ifdef RUN_CTRL_WDOG_EN
    // Timeout only when the limit, not the end PC, ends the run.
    always_comb begin
        timeout_d = timeout_q;
        if (start) begin
            timeout_d = 1'b0;
        end else if ((state_q == ST_RUN) && !end_hit && wdog_hit) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`endif

endmodule
